mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15 — maximum wait, in cycles, for mem_ready before an access aborts.
REQ-002 Parameter: FAIR_LIMIT, default 4 — consecutive data grants allowed while a fetch waits.
REQ-003 Port: clk  in  1  — single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  — reset, asynchronous and active-low.
REQ-005 Ports, fetch requester:
- if_req  in  1  — fetch request; held high until if_valid.
- if_addr  in  32  — fetch address.
- if_valid  out  1  — one-cycle fetch completion pulse.
- if_rdata  out  32  — fetched word.
REQ-006 Ports, data requester:
- d_req  in  1  — data request; held high until d_valid.
- d_we  in  1  — 1 = write, 0 = read.
- d_addr  in  32  — data address.
- d_wdata  in  32  — write data.
- d_valid  out  1  — one-cycle data completion pulse.
- d_rdata  out  32  — read data.
REQ-007 Ports, shared memory:
- mem_en  out  1  — access active.
- mem_we  out  1  — write strobe.
- mem_addr  out  32  — memory address.
- mem_wdata  out  32  — memory write data.
- mem_rdata  in  32  — memory read data.
- mem_ready  in  1  — access complete.
REQ-008 Ports, status:
- stall_if  out  1  — fetch stall to the IF stage.
- stall_mem  out  1  — data stall to the MEM stage.
- err  out  1  — one-cycle timeout pulse.

Function
REQ-009 FSM states: IDLE, IF_ACC, D_ACC.
- IDLE -> D_ACC when d_req and not fetch-forced.
- IDLE -> IF_ACC when if_req and (d_req low or fetch-forced).
- Otherwise remain in IDLE.
REQ-010 Fetch-forced means starve_cnt == FAIR_LIMIT and if_req high.
REQ-011 On entering an ACC state, register mem_addr, mem_we and mem_wdata from the granted requester:
- mem_en=1 from the following cycle until the cycle mem_ready is sampled high.
- mem_we=d_we only in D_ACC; 0 in IF_ACC.
- Address and data fields are held stable while mem_en=1.
REQ-012 When mem_ready is sampled high in an ACC state:
- The next cycle pulses the granted requester's valid for one cycle.
- A fetch or data read registers mem_rdata into that requester's rdata.
- Data writes leave d_rdata unchanged.
- FSM returns to IDLE.
REQ-013 Minimum access time is 3 cycles (grant, mem_en, valid). IDLE lasts at least one cycle between accesses.
REQ-014 Wait counter:
- Clears on ACC entry and increments each ACC cycle without mem_ready.
- On reaching TIMEOUT: drop mem_en, pulse the granted valid with rdata 32'h0 (writes: d_rdata unchanged), pulse err the same cycle, and return to IDLE.
REQ-015 starve_cnt (3-bit, saturating at FAIR_LIMIT):
- Increments on each D_ACC grant while if_req is high.
- Clears on each IF_ACC grant, and on any D_ACC grant while if_req is low.
REQ-016 stall_if = if_req & ~if_valid; stall_mem = d_req & ~d_valid. Both are combinational.
REQ-017 mem_ready asserted in IDLE is ignored.
REQ-018 Requester address or data changes during an access are ignored.
REQ-019 if_req and d_req rising in the same IDLE cycle grant data, unless fetch-forced.
REQ-020 A requester dropping its req mid-access does not abort the access. The valid pulse is still issued.

Reset
REQ-021 rst low immediately forces:
- FSM = IDLE; starve_cnt = 0; wait counter = 0.
- mem_en = mem_we = 0; if_valid = d_valid = err = 0.
- mem_addr, mem_wdata, if_rdata, d_rdata = 32'h0.
REQ-022 Reset asserted mid-access abandons the access with no valid pulse. The first grant is possible in the first clock edge after rst rises.

Verification
REQ-023 Fetch only, if_addr=0x40, mem_ready high on first mem_en cycle, mem_rdata=0x8C010004 -> mem_en one cycle with mem_addr=0x40, if_valid at cycle 3, if_rdata=0x8C010004, stall_if low after.
REQ-024 if_req and d_req (write, d_addr=0x10, d_wdata=0xDEADBEEF) same cycle -> data granted first with mem_we=1, d_valid pulse, then fetch granted, if_valid pulse.
REQ-025 Continuous d_req and if_req, mem_ready immediate -> exactly 4 data accesses, then 1 fetch, starve_cnt back to 0.
REQ-026 Data read, mem_ready never asserted -> after 15 ACC cycles, mem_en drops, d_valid=1, d_rdata=0, err=1 for one cycle.
REQ-027 rst pulled low 1 cycle after mem_en rises -> mem_en=0 asynchronously, no valid pulse. After release, pending if_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: serves one fetch and one data requester over a
// single memory port. Data wins ties unless the fetch side has been passed
// over FAIR_LIMIT times in a row; a stalled access aborts after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 15,
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    // shared memory
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    // status
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        starve_cnt;
    logic              fetch_forced;
    logic              grant_d;
    logic              grant_if;
    logic              done;
    logic              timed_out;
    logic              finish;

    // The port is busy for exactly the cycles spent in an access state.
    assign mem_en    = (state != IDLE);
    assign finish    = done | timed_out;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    // Next-state and grant decisions. No grant is made while a completion
    // pulse is out, so the finishing requester can drop its request first.
    always_comb begin
        state_next   = state;
        grant_d      = 1'b0;
        grant_if     = 1'b0;
        done         = 1'b0;
        timed_out    = 1'b0;
        fetch_forced = (starve_cnt == 3'(FAIR_LIMIT)) && if_req;
        case (state)
            IDLE: begin
                if (!if_valid && !d_valid) begin
                    if (d_req && !fetch_forced) begin
                        grant_d    = 1'b1;
                        state_next = D_ACC;
                    end else if (if_req) begin
                        grant_if   = 1'b1;
                        state_next = IF_ACC;
                    end
                end
            end
            IF_ACC, D_ACC: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Wait counter per access and fetch starvation counter (saturating).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_d || grant_if)
                wait_cnt <= '0;
            else if (mem_en && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (grant_if)
                starve_cnt <= '0;
            else if (grant_d) begin
                if (!if_req)
                    starve_cnt <= '0;
                else if (starve_cnt < 3'(FAIR_LIMIT))
                    starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Latch the granted request, then deliver the completion (or timeout) pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_we    <= d_we;
            end else if (grant_if) begin
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_we    <= 1'b0;
            end else if (finish) begin
                mem_we    <= 1'b0;
            end

            if (finish) begin
                err <= timed_out;
                if (state == IF_ACC) begin
                    if_valid <= 1'b1;
                    if_rdata <= timed_out ? 32'h0 : mem_rdata;
                end else begin
                    d_valid <= 1'b1;
                    if (!mem_we)
                        d_rdata <= timed_out ? 32'h0 : mem_rdata;
                end
            end
        end
    end

endmodule
